// File: rtl/fifo_tx_serializer_pkg.sv
// Shared constants and FSM encoding for the FIFO drain serializer.
// The FIFO and the serializer take their word width from here.
package fifo_tx_serializer_pkg;

    localparam int unsigned DATA_WIDTH   = 16;
    localparam int unsigned CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/fifo_tx_serializer_bit_timer.sv
// Serial bit period counter: pulses bit_end on the last cycle of a bit.
// Holds at zero while restart is high and wraps on its own at each bit end.
module bit_timer #(
    parameter int unsigned clks_per_bit = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from the FIFO and shifts them out as start/data(LSB first)/stop frames.
// All outputs are decoded from registered state, so reset forces them immediately.
module fifo_tx_serializer
    import fifo_tx_serializer_pkg::*;
#(
    parameter int unsigned width        = DATA_WIDTH,
    parameter int unsigned clks_per_bit = CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data,
    output logic             re,
    output logic             tx,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned IW = (width > 1) ? $clog2(width) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(width - 1);

    tx_state_t        state_q, state_d;
    logic [width-1:0] shreg_q;
    logic [IW-1:0]    idx_q;
    logic             bit_end;
    logic             timer_restart;

    // Timer sits at zero before the frame so START gets a full bit period
    assign timer_restart = (state_q == IDLE) || (state_q == READ) ||
                           (state_q == LOAD);

    bit_timer #(
        .clks_per_bit(clks_per_bit)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(timer_restart),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else if (state_q == LOAD) begin
            shreg_q <= fifo_data;
            idx_q   <= '0;
        end else if (state_q == DATA && bit_end) begin
            shreg_q <= shreg_q >> 1;
            idx_q   <= idx_q + IW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        re        = 1'b0;
        tx        = 1'b1;
        busy      = 1'b1;
        word_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (tx_en && !fifo_empty) state_d = READ;
            end
            READ: begin
                re      = 1'b1;
                state_d = LOAD;
            end
            LOAD: state_d = START;
            START: begin
                tx = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                tx = shreg_q[0];
                if (bit_end && idx_q == LAST_IDX) state_d = STOP;
            end
            STOP: begin
                word_done = bit_end;
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
